// File: rtl/rob_buf_pkg.sv
// Shared types for the outgoing R-channel burst buffer: beat entry layout,
// RRESP encodings and the store-and-forward state enum.
package rob_buf_pkg;

  localparam int ID_W   = 32;
  localparam int DATA_W = 64;
  localparam int RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;
  } r_entry_t;

  localparam int ENTRY_W = $bits(r_entry_t);

  typedef enum logic {
    HOLD  = 1'b0,
    DRAIN = 1'b1
  } buf_state_e;

  // Any non-OKAY response is treated as an error beat.
  function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/r_if.sv
// AXI R-channel bundle; receiver takes beats in, sender drives beats out.
interface r_if #(
  parameter int ID_WIDTH   = rob_buf_pkg::ID_W,
  parameter int DATA_WIDTH = rob_buf_pkg::DATA_W,
  parameter int RESP_WIDTH = rob_buf_pkg::RESP_W
);
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport receiver (input id, data, resp, last, valid, output ready);
  modport sender   (output id, data, resp, last, valid, input ready);
endinterface

// File: rtl/rob_fifo_core.sv
// Plain FIFO storage with explicit pointer wrap so any DEPTH works,
// including non-powers of two. Caller guarantees no push when full / pop when empty.
module rob_fifo_core
  import rob_buf_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = ENTRY_W,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/outgoing_r_burst_buffer.sv
// Outgoing R-channel buffer with optional per-burst store-and-forward.
// Optional error-response counter port err_cnt enabled by OUTGOING_R_BUF_ERR_CNT_EN.
module outgoing_r_burst_buffer
  import rob_buf_pkg::*;
#(
  parameter int  ID_WIDTH     = ID_W,
  parameter int  DATA_WIDTH   = DATA_W,
  parameter int  RESP_WIDTH   = RESP_W,
  parameter int  DEPTH        = 16,
  parameter int  AFULL_THRESH = DEPTH - 2,
  parameter int  STORE_FWD    = 1,
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  r_if.receiver            r_in,
  r_if.sender              r_out,
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic [CNT_W-1:0] bursts_stored
`ifdef OUTGOING_R_BUF_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  r_entry_t           wr_entry;
  r_entry_t           head;
  logic [ENTRY_W-1:0] rd_data;
  logic               push, pop;
  logic               full, empty;
  logic               out_vld;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   bursts_q, bursts_d;
  buf_state_e         state_q, state_d;

  // No bypass when full: a same-cycle pop does not open a slot for the push.
  assign r_in.ready = ~full;
  assign push       = r_in.valid & ~full;
  assign pop        = out_vld & r_out.ready;

  always_comb begin
    wr_entry      = '0;
    wr_entry.id   = ID_W'(r_in.id);
    wr_entry.data = DATA_W'(r_in.data);
    wr_entry.resp = RESP_W'(r_in.resp);
    wr_entry.last = r_in.last;
  end

  rob_fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign head = rd_data;

  always_comb begin
    bursts_d = bursts_q;
    case ({push & r_in.last, pop & head.last})
      2'b10:   bursts_d = bursts_q + CNT_W'(1);
      2'b01:   bursts_d = bursts_q - CNT_W'(1);
      default: bursts_d = bursts_q;
    endcase
  end

  // HOLD exposes beats only once a whole burst is stored; a burst larger than
  // the buffer would never complete, so a full buffer with no complete burst
  // switches to cut-through until that burst's last beat leaves.
  always_comb begin
    state_d = state_q;
    out_vld = ~empty;
    if (STORE_FWD != 0) begin
      case (state_q)
        HOLD: begin
          out_vld = (bursts_q != '0);
          if (full && (bursts_q == '0)) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          out_vld = ~empty;
          if (!empty && r_out.ready && head.last) begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = HOLD;
          out_vld = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HOLD;
      bursts_q <= '0;
    end else begin
      state_q  <= state_d;
      bursts_q <= bursts_d;
    end
  end

  always_comb begin
    r_out.valid = out_vld;
    r_out.id    = '0;
    r_out.data  = '0;
    r_out.resp  = '0;
    r_out.last  = 1'b0;
    if (out_vld) begin
      r_out.id   = ID_WIDTH'(head.id);
      r_out.data = DATA_WIDTH'(head.data);
      r_out.resp = RESP_WIDTH'(head.resp);
      r_out.last = head.last;
    end
  end

  assign count         = fifo_count;
  assign bursts_stored = bursts_q;
  assign almost_full   = (int'(fifo_count) >= AFULL_THRESH);

`ifdef OUTGOING_R_BUF_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pop && resp_is_err(head.resp) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_outgoing_r_burst_buffer.sv
// Bench for outgoing_r_burst_buffer: three configurations checked every cycle
// against a queue-based model, plus directed scenarios with literal expectations.
module tb_outgoing_r_burst_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic        in_valid  [3];
  logic        in_last   [3];
  logic [31:0] in_id     [3];
  logic [63:0] in_data   [3];
  logic [1:0]  in_resp   [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [98:0] out_pl    [3];
  int          cnt       [3];
  int          bst       [3];
  logic        af        [3];
`ifdef OUTGOING_R_BUF_ERR_CNT_EN
  logic [15:0] errc      [3];
`endif

  logic [4:0] count0, bursts0;
  logic [2:0] count1, bursts1, count2, bursts2;

  r_if i0 ();
  r_if o0 ();
  r_if i1 ();
  r_if o1 ();
  r_if i2 ();
  r_if o2 ();

  assign i0.valid = in_valid[0];
  assign i0.last  = in_last[0];
  assign i0.id    = in_id[0];
  assign i0.data  = in_data[0];
  assign i0.resp  = in_resp[0];
  assign o0.ready = out_ready[0];
  assign in_ready[0]  = i0.ready;
  assign out_valid[0] = o0.valid;
  assign out_pl[0]    = {o0.id, o0.data, o0.resp, o0.last};
  assign cnt[0] = int'(count0);
  assign bst[0] = int'(bursts0);

  assign i1.valid = in_valid[1];
  assign i1.last  = in_last[1];
  assign i1.id    = in_id[1];
  assign i1.data  = in_data[1];
  assign i1.resp  = in_resp[1];
  assign o1.ready = out_ready[1];
  assign in_ready[1]  = i1.ready;
  assign out_valid[1] = o1.valid;
  assign out_pl[1]    = {o1.id, o1.data, o1.resp, o1.last};
  assign cnt[1] = int'(count1);
  assign bst[1] = int'(bursts1);

  assign i2.valid = in_valid[2];
  assign i2.last  = in_last[2];
  assign i2.id    = in_id[2];
  assign i2.data  = in_data[2];
  assign i2.resp  = in_resp[2];
  assign o2.ready = out_ready[2];
  assign in_ready[2]  = i2.ready;
  assign out_valid[2] = o2.valid;
  assign out_pl[2]    = {o2.id, o2.data, o2.resp, o2.last};
  assign cnt[2] = int'(count2);
  assign bst[2] = int'(bursts2);

  outgoing_r_burst_buffer #(.DEPTH(16), .STORE_FWD(1)) u0 (
    .clk(clk), .rst(rst), .r_in(i0), .r_out(o0),
    .count(count0), .almost_full(af[0]), .bursts_stored(bursts0)
`ifdef OUTGOING_R_BUF_ERR_CNT_EN
    , .err_cnt(errc[0])
`endif
  );

  outgoing_r_burst_buffer #(.DEPTH(6), .STORE_FWD(1)) u1 (
    .clk(clk), .rst(rst), .r_in(i1), .r_out(o1),
    .count(count1), .almost_full(af[1]), .bursts_stored(bursts1)
`ifdef OUTGOING_R_BUF_ERR_CNT_EN
    , .err_cnt(errc[1])
`endif
  );

  outgoing_r_burst_buffer #(.DEPTH(5), .STORE_FWD(0)) u2 (
    .clk(clk), .rst(rst), .r_in(i2), .r_out(o2),
    .count(count2), .almost_full(af[2]), .bursts_stored(bursts2)
`ifdef OUTGOING_R_BUF_ERR_CNT_EN
    , .err_cnt(errc[2])
`endif
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no completion, expected completion", nm);
  endtask

  // Model: per-instance beat log with monotonic head/tail indices.
  int          depth_m [3] = '{16, 6, 5};
  int          thr_m   [3] = '{14, 4, 3};
  bit          sf_m    [3] = '{1'b1, 1'b1, 1'b0};
  logic [98:0] log_m   [3][256];
  int          hd      [3] = '{0, 0, 0};
  int          tl      [3] = '{0, 0, 0};
  bit          drain_m [3] = '{1'b0, 1'b0, 1'b0};
  int          err_m   [3] = '{0, 0, 0};
  bit          model_ok = 1'b0;
  int          mc, mb;
  bit          mv, mpush, mpop;
  logic [98:0] mexp;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      mc = tl[k] - hd[k];
      mb = 0;
      for (int i = hd[k]; i < tl[k]; i++) mb += int'(log_m[k][i % 256][0]);
      mv   = (sf_m[k] && !drain_m[k]) ? (mb != 0) : (mc != 0);
      mexp = mv ? log_m[k][hd[k] % 256] : '0;
      if (model_ok) begin
        chk($sformatf("u%0d count", k), cnt[k], mc);
        chk($sformatf("u%0d bursts_stored", k), bst[k], mb);
        chk($sformatf("u%0d in_ready", k), in_ready[k], mc < depth_m[k]);
        chk($sformatf("u%0d out_valid", k), out_valid[k], mv);
        chk($sformatf("u%0d payload", k), out_pl[k], mexp);
        chk($sformatf("u%0d almost_full", k), af[k], mc >= thr_m[k]);
`ifdef OUTGOING_R_BUF_ERR_CNT_EN
        chk($sformatf("u%0d err_cnt", k), errc[k], err_m[k]);
`endif
      end
      if (rst) begin
        hd[k]      = tl[k];
        drain_m[k] = 1'b0;
        err_m[k]   = 0;
      end else begin
        mpush = in_valid[k] && (mc < depth_m[k]);
        mpop  = mv && out_ready[k];
        if (sf_m[k] && !drain_m[k] && (mc == depth_m[k]) && (mb == 0)) drain_m[k] = 1'b1;
        else if (drain_m[k] && mpop && mexp[0]) drain_m[k] = 1'b0;
        if (mpop) begin
          hd[k]++;
          if ((mexp[2:1] != 2'b00) && (err_m[k] < 65535)) err_m[k]++;
        end
        if (mpush) begin
          log_m[k][tl[k] % 256] = {in_id[k], in_data[k], in_resp[k], in_last[k]};
          tl[k]++;
        end
      end
    end
    if (rst) model_ok = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int k, input logic [31:0] id, input logic [63:0] d,
                           input logic [1:0] rs, input logic lst);
    bit done = 1'b0;
    in_valid[k] = 1'b1;
    in_id[k]    = id;
    in_data[k]  = d;
    in_resp[k]  = rs;
    in_last[k]  = lst;
    for (int t = 0; t < 100 && !done; t++) begin
      done = in_ready[k];
      step();
    end
    in_valid[k] = 1'b0;
    if (!done) tmo($sformatf("u%0d push", k));
  endtask

  task automatic wait_empty(input int k);
    for (int t = 0; t < 200 && cnt[k] != 0; t++) step();
    if (cnt[k] != 0) tmo($sformatf("u%0d drain to empty", k));
  endtask

  int  sent, rcvd, maxc;
  bit  acc, pp;

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_last[k]   = 1'b0;
      in_id[k]     = '0;
      in_data[k]   = '0;
      in_resp[k]   = '0;
      out_ready[k] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset count u%0d", k), cnt[k], 0);
      chk($sformatf("reset bursts u%0d", k), bst[k], 0);
      chk($sformatf("reset in_ready u%0d", k), in_ready[k], 1);
      chk($sformatf("reset out_valid u%0d", k), out_valid[k], 0);
      chk($sformatf("reset payload u%0d", k), out_pl[k], 0);
      chk($sformatf("reset almost_full u%0d", k), af[k], 0);
    end

    // 4-beat burst, store-and-forward, DEPTH 16
    out_ready[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push_beat(0, 32'h5, 64'h100 + 64'(i), 2'b00, 1'b0);
      chk("sf4 valid before last", out_valid[0], 0);
    end
    push_beat(0, 32'h5, 64'h104, 2'b00, 1'b1);
    chk("sf4 valid after last", out_valid[0], 1);
    chk("sf4 bursts after last", bst[0], 1);
    chk("sf4 beat1 data", out_pl[0][66:3], 64'h101);
    step();
    chk("sf4 beat2 data", out_pl[0][66:3], 64'h102);
    step();
    chk("sf4 beat3 data", out_pl[0][66:3], 64'h103);
    step();
    chk("sf4 beat4 data", out_pl[0][66:3], 64'h104);
    chk("sf4 beat4 last", out_pl[0][0], 1);
    step();
    chk("sf4 valid after drain", out_valid[0], 0);
    chk("sf4 bursts after drain", bst[0], 0);

    // Oversize 9-beat burst, DEPTH 6
    out_ready[1] = 1'b0;
    for (int i = 1; i <= 6; i++) push_beat(1, 32'h7, 64'h200 + 64'(i), 2'b00, 1'b0);
    chk("big count full", cnt[1], 6);
    chk("big in_ready full", in_ready[1], 0);
    chk("big valid before drain", out_valid[1], 0);
    step();
    chk("big valid in drain", out_valid[1], 1);
    chk("big first data", out_pl[1][66:3], 64'h201);
    out_ready[1] = 1'b1;
    push_beat(1, 32'h7, 64'h207, 2'b00, 1'b0);
    push_beat(1, 32'h7, 64'h208, 2'b00, 1'b0);
    push_beat(1, 32'h7, 64'h209, 2'b00, 1'b1);
    wait_empty(1);
    step();
    chk("big valid after drain", out_valid[1], 0);
    push_beat(1, 32'h8, 64'h2AA, 2'b00, 1'b0);
    chk("big back in hold", out_valid[1], 0);
    push_beat(1, 32'h8, 64'h2AB, 2'b00, 1'b1);
    chk("big next burst visible", out_pl[1][66:3], 64'h2AA);
    wait_empty(1);
    out_ready[1] = 1'b0;

    // Cut-through, DEPTH 5, random handshakes over several wraps
    sent = 0;
    rcvd = 0;
    maxc = 0;
    for (int c = 0; c < 600 && rcvd < 20; c++) begin
      out_ready[2] = 1'($urandom_range(0, 1));
      if (!in_valid[2] && sent < 20 && $urandom_range(0, 2) != 0) begin
        in_valid[2] = 1'b1;
        in_id[2]    = 32'(sent);
        in_data[2]  = 64'h300 + 64'(sent);
        in_resp[2]  = 2'b00;
        in_last[2]  = (sent % 4 == 3);
      end
      acc = in_valid[2] && in_ready[2];
      pp  = out_valid[2] && out_ready[2];
      if (cnt[2] > maxc) maxc = cnt[2];
      if (pp) begin
        chk("ct order", out_pl[2][66:3], 64'h300 + 64'(rcvd));
        rcvd++;
      end
      step();
      if (acc) begin
        in_valid[2] = 1'b0;
        sent++;
      end
    end
    chk("ct beats delivered", rcvd, 20);
    chk("ct count bounded", maxc <= 5, 1);
    out_ready[2] = 1'b0;
    in_valid[2]  = 1'b0;
    step();

    // Full with simultaneous push request and pop
    for (int i = 0; i < 5; i++) push_beat(2, 32'h40, 64'h400 + 64'(i), 2'b00, 1'b1);
    chk("full count", cnt[2], 5);
    chk("full in_ready", in_ready[2], 0);
    chk("full almost_full", af[2], 1);
    in_valid[2] = 1'b1;
    in_id[2]    = 32'h41;
    in_data[2]  = 64'h4AA;
    in_last[2]  = 1'b1;
    out_ready[2] = 1'b1;
    step();
    chk("full no bypass count", cnt[2], 4);
    step();
    chk("push and pop count", cnt[2], 4);
    in_valid[2] = 1'b0;
    wait_empty(2);
    out_ready[2] = 1'b0;
    step();

    // Reset mid-operation
    for (int i = 0; i < 3; i++) push_beat(2, 32'h50, 64'h500 + 64'(i), 2'b00, 1'b1);
    chk("pre-reset valid", out_valid[2], 1);
    in_valid[2] = 1'b1;
    in_data[2]  = 64'h5FF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid[2] = 1'b0;
    chk("post-reset count", cnt[2], 0);
    chk("post-reset valid", out_valid[2], 0);
    chk("post-reset data", out_pl[2][66:3], 64'h0);
    chk("post-reset in_ready", in_ready[2], 1);
    out_ready[2] = 1'b1;
    push_beat(2, 32'h77, 64'hDEAD, 2'b00, 1'b1);
    chk("post-reset beat data", out_pl[2][66:3], 64'hDEAD);
    chk("post-reset beat id", out_pl[2][98:67], 32'h77);
    step();
    chk("post-reset beat gone", out_valid[2], 0);
    out_ready[2] = 1'b0;

    // Error responses 0,2,3,2
    out_ready[0] = 1'b1;
    push_beat(0, 32'h60, 64'h600, 2'b00, 1'b1);
    push_beat(0, 32'h61, 64'h601, 2'b10, 1'b1);
    push_beat(0, 32'h62, 64'h602, 2'b11, 1'b1);
    push_beat(0, 32'h63, 64'h603, 2'b10, 1'b1);
    wait_empty(0);
    step();
`ifdef OUTGOING_R_BUF_ERR_CNT_EN
    chk("err_cnt after 0,2,3,2", errc[0], 16'd3);
`endif
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
